// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Word-addressed 32-bit data memory behind a fixed-latency request/response
//   handshake. A request is accepted in IDLE, and the requester is stalled
//   while the access waits out LATENCY cycles. A one-cycle resp_valid pulse
//   (with err) marks completion. Misaligned addresses and simultaneous
//   read+write are error requests. These take the same time as a normal
//   access but touch neither the array nor rdata.
//
// Parameters
//   ADDR_BITS  word-address width, array depth 2**ADDR_BITS (1..29)
//   LATENCY    wait cycles between acceptance and the access (0..15)
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous active-low reset
//   req_read    read request
//   req_write   write request
//   addr        byte address (word index = addr[ADDR_BITS+1:2])
//   wdata       store data
//   stall       combinational freeze of the requester pipeline
//   resp_valid  one-cycle completion pulse
//   rdata       registered read data, held until the next successful read
//   err         error flag, meaningful only with resp_valid
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam bit       ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_M1 = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             cnt;
  logic                   access;

  // Operation latched at acceptance; the inputs are don't-care after that.
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic                   rd_q;
  logic                   wr_q;
  logic                   err_q;

  logic [31:0]            mem [2**ADDR_BITS];

  logic                   req;
  logic                   req_err;
  logic                   accept;
  logic [ADDR_BITS-1:0]   addr_idx;

  // Operands of the access. With zero latency the access happens on the
  // same edge as acceptance, so they come straight from the inputs.
  logic [ADDR_BITS-1:0]   acc_idx;
  logic [31:0]            acc_wdata;
  logic                   acc_rd;
  logic                   acc_wr;
  logic                   acc_err;

  // Upper address bits alias onto the array by design.
  logic                   unused_addr_hi;

  assign req            = req_read | req_write;
  assign req_err        = (addr[1:0] != 2'b00) | (req_read & req_write);
  assign addr_idx       = addr[ADDR_BITS+1:2];
  assign accept         = (state == IDLE) & req;
  assign unused_addr_hi = ^addr[31:ADDR_BITS+2];

  assign acc_idx   = (state == IDLE) ? addr_idx  : idx_q;
  assign acc_wdata = (state == IDLE) ? wdata     : wdata_q;
  assign acc_rd    = (state == IDLE) ? req_read  : rd_q;
  assign acc_wr    = (state == IDLE) ? req_write : wr_q;
  assign acc_err   = (state == IDLE) ? req_err   : err_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, stall and the access strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt = state;
    stall     = 1'b0;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (ZERO_LAT) begin
            state_nxt = DONE;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          access    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The requester must never be frozen while this block is held in reset.
    if (!RST) stall = 1'b0;
  end

  assign resp_valid = RST & (state == DONE);
  assign err        = RST & (state == DONE) & err_q;

  // Wait counter, request latch and read data.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the values from before this edge.
    if (!RST) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      if (accept) begin
        idx_q   <= addr_idx;
        wdata_q <= wdata;
        rd_q    <= req_read;
        wr_q    <= req_write;
        err_q   <= req_err;
        cnt     <= LAT_M1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && acc_rd && !acc_err) rdata <= mem[acc_idx];
    end
  end

  // NOTE: the array has no reset. Its contents survive RST. The RST term
  // only stops a write whose access edge coincides with a reset.
  always_ff @(posedge CLK) begin
    if (RST && access && acc_wr && !acc_err) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. It drives one instance with
//   LATENCY=2 and one with LATENCY=0, both using ADDR_BITS=8.
//   Each access is checked cycle by cycle against the expected
//   stall/resp_valid timing, err and rdata. A word-level model of the memory
//   supplies the expected values for the randomized phase.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  logic        req_read, req_write;
  logic [31:0] addr, wdata;
  logic        stall, resp_valid, err;
  logic [31:0] rdata;

  logic        z_req_read, z_req_write;
  logic [31:0] z_addr, z_wdata;
  logic        z_stall, z_resp_valid, z_err;
  logic [31:0] z_rdata;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req_read(req_read), .req_write(req_write), .addr(addr), .wdata(wdata),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .err(err)
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .req_read(z_req_read), .req_write(z_req_write), .addr(z_addr), .wdata(z_wdata),
    .stall(z_stall), .resp_valid(z_resp_valid), .rdata(z_rdata), .err(z_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one word per index, plus a flag per word saying
  // whether it has been written since time zero.
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem   [256];
  bit          m_known [256];
  logic [31:0] m_rdata;
  bit          m_rdata_known;

  task automatic model(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output bit e, output logic [31:0] r, output bit chk);
    int w;
    w = int'((a / 32'd4) % 32'd256);
    e = (a % 32'd4 != 0) || (rd && wr);
    if (!e && wr) begin
      m_mem[w]   = d;
      m_known[w] = 1'b1;
    end
    if (!e && rd) begin
      m_rdata_known = m_known[w];
      m_rdata       = m_mem[w];
    end
    r   = m_rdata;
    chk = m_rdata_known;
  endtask

  task automatic idle_inputs();
    req_read = 1'b0; req_write = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  // Issue one request to the LATENCY=2 instance and check every cycle up to
  // and including the response. On entry and exit the time is just after a
  // rising edge. Random junk is driven during WAIT.
  task automatic op(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                    input logic [31:0] d, input bit e, input logic [31:0] r, input bit chk);
    req_read = rd; req_write = wr; addr = a; wdata = d;
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge CLK);
      check($sformatf("%s stall c%0d", tag, c), 32'(stall), 32'(c <= LAT));
      check($sformatf("%s resp_valid c%0d", tag, c), 32'(resp_valid), 32'(c == LAT + 1));
      if (c == LAT + 1) begin
        check($sformatf("%s err", tag), 32'(err), 32'(e));
        if (chk) check($sformatf("%s rdata", tag), rdata, r);
      end
      @(posedge CLK); #1;
      if (c + 1 <= LAT) begin
        req_read  = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        addr      = $urandom;
        wdata     = $urandom;
      end else begin
        idle_inputs();
      end
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          e;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          exp_stall;
    bit          exp_rv;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
  } zcyc_t;

  initial begin
    vec_t        tbl  [10];
    zcyc_t       zseq [9];
    bit          e, chk;
    logic [31:0] r;
    int          kind;
    logic [31:0] a, d;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0013, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0410, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[8] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1234_5678};
    tbl[9] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h1234_5678};

    // Zero-latency cycles: write, aliased read, then a read held for two
    // cycles, which is accepted again in the cycle after DONE.
    zseq[0] = '{1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 32'h0};
    zseq[1] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    zseq[2] = '{1'b1, 1'b0, 32'h0000_0444, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
    zseq[3] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
    zseq[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
    zseq[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
    zseq[6] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
    zseq[7] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
    zseq[8] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_rdata = 32'd0; m_rdata_known = 1'b1;

    // ---- Reset: a request is present, yet everything stays quiet --------
    RST = 1'b0;
    req_read = 1'b1; req_write = 1'b0; addr = 32'h10; wdata = 32'd0;
    z_req_read = 1'b1; z_req_write = 1'b0; z_addr = 32'h10; z_wdata = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset stall",        32'(stall),        32'd0);
    check("reset resp_valid",   32'(resp_valid),   32'd0);
    check("reset err",          32'(err),          32'd0);
    check("reset rdata",        rdata,             32'd0);
    check("reset z_stall",      32'(z_stall),      32'd0);
    check("reset z_resp_valid", 32'(z_resp_valid), 32'd0);
    check("reset z_rdata",      z_rdata,           32'd0);
    @(posedge CLK); #1;
    z_req_read = 1'b0; z_addr = 32'd0;
    RST = 1'b1;

    // ---- Directed table; the first request lands in the first RST=1 cycle
    for (int i = 0; i < 10; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, e, r, chk);
      op($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
         tbl[i].e, tbl[i].r, 1'b1);
    end

    // ---- Back-to-back: write held through DONE, read in the next cycle ---
    model(1'b0, 1'b1, 32'h30, 32'h0BAD_F00D, e, r, chk);
    model(1'b1, 1'b0, 32'h30, 32'h0,         e, r, chk);
    for (int c = 0; c <= 8; c++) begin
      if (c <= 3) begin
        req_read = 1'b0; req_write = 1'b1; addr = 32'h30; wdata = 32'h0BAD_F00D;
      end else if (c == 4) begin
        req_read = 1'b1; req_write = 1'b0; addr = 32'h30; wdata = 32'd0;
      end else begin
        idle_inputs();
      end
      @(negedge CLK);
      check($sformatf("b2b stall c%0d", c), 32'(stall),
            32'((c <= 2) || (c >= 4 && c <= 6)));
      check($sformatf("b2b resp_valid c%0d", c), 32'(resp_valid), 32'(c == 3 || c == 7));
      if (c == 3 || c == 7) check($sformatf("b2b err c%0d", c), 32'(err), 32'd0);
      if (c == 7) check("b2b rdata", rdata, 32'h0BAD_F00D);
      @(posedge CLK); #1;
    end
    idle_inputs();

    // ---- Reset on the access cycle of a pending write aborts it ----------
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) begin
        req_read = 1'b0; req_write = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
      end else begin
        idle_inputs();
      end
      RST = (c == 2) ? 1'b0 : 1'b1;
      @(negedge CLK);
      check($sformatf("abort stall c%0d", c), 32'(stall), 32'(c <= 1));
      check($sformatf("abort resp_valid c%0d", c), 32'(resp_valid), 32'd0);
      check($sformatf("abort err c%0d", c), 32'(err), 32'd0);
      if (c >= 3) check($sformatf("abort rdata c%0d", c), rdata, 32'd0);
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    m_rdata = 32'd0; m_rdata_known = 1'b1;
    model(1'b1, 1'b0, 32'h20, 32'h0, e, r, chk);
    op("after_abort", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, 1'b1);

    // ---- Zero-latency instance ------------------------------------------
    for (int c = 0; c < 9; c++) begin
      z_req_read = zseq[c].rd; z_req_write = zseq[c].wr;
      z_addr = zseq[c].a; z_wdata = zseq[c].d;
      @(negedge CLK);
      check($sformatf("lat0 stall c%0d", c), 32'(z_stall), 32'(zseq[c].exp_stall));
      check($sformatf("lat0 resp_valid c%0d", c), 32'(z_resp_valid), 32'(zseq[c].exp_rv));
      if (zseq[c].exp_rv) check($sformatf("lat0 err c%0d", c), 32'(z_err), 32'd0);
      if (zseq[c].chk_rdata)
        check($sformatf("lat0 rdata c%0d", c), z_rdata, zseq[c].exp_rdata);
      @(posedge CLK); #1;
    end
    z_req_read = 1'b0; z_req_write = 1'b0; z_addr = 32'd0; z_wdata = 32'd0;

    // ---- Randomized accesses against the model --------------------------
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      a = a | ($urandom & 32'hFFFF_FC00);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      model(kind == 0 || kind >= 5, kind <= 4, a, d, e, r, chk);
      op($sformatf("rnd%0d", i), kind == 0 || kind >= 5, kind <= 4, a, d, e, r, chk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-low.
REQ-002 Parameter ADDR_BITS, default 8, SHALL set word-address width (array depth 2^ADDR_BITS x 32).
REQ-003 Parameter LATENCY, default 2, SHALL set the number of wait cycles, legal range 0..15.
REQ-004 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  synchronous active-low reset.
REQ-006 req_read  input  1  read request (MemRead).
REQ-007 req_write  input  1  write request (MemWrite).
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data.
REQ-010 stall  output  1  freeze requester pipeline.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  registered read data.
REQ-013 err  output  1  one-cycle error flag, valid only with resp_valid.

Function
REQ-014 FSM SHALL have states IDLE, WAIT and DONE, with a 4-bit wait counter.
REQ-015 IDLE: when req_read or req_write is 1, the block SHALL latch addr, wdata and opcode, and accept the request.
  - LATENCY=0: perform the access and go to DONE.
  - Otherwise: load counter with LATENCY-1 and go to WAIT.
REQ-016 WAIT: counter=0 SHALL perform the access and go to DONE; otherwise the counter SHALL decrement.
REQ-017 DONE: resp_valid=1, next state IDLE; request inputs SHALL be ignored in DONE (no re-accept of the held request).
REQ-018 stall SHALL be combinational: 1 when in WAIT, or in IDLE with a request present; 0 in DONE and when RST=0.
REQ-019 With request in cycle 0, stall SHALL be 1 in cycles 0..LATENCY and resp_valid 1 in cycle LATENCY+1.
REQ-020 Throughput SHALL be one access per LATENCY+2 cycles; a new request in the cycle after DONE SHALL be accepted.
REQ-021 Word index SHALL be addr[ADDR_BITS+1:2]; higher address bits SHALL be ignored (aliasing/wrap).
REQ-022 Write access SHALL store the latched wdata into the array on the edge that enters DONE.
REQ-023 Read access SHALL capture the array word into rdata on the edge that enters DONE.
REQ-024 rdata SHALL hold its value until the next successful read.
REQ-025 Error request: addr[1:0]!=0, or req_read and req_write both 1 at acceptance.
  - SHALL use identical timing to a normal access.
  - SHALL leave the array and rdata unchanged.
  - SHALL assert err=1 together with resp_valid.
REQ-026 Inputs changing while in WAIT SHALL have no effect; the latched operation completes.
REQ-027 The array SHALL have no reset; contents SHALL persist across reset.

Reset
REQ-028 RST=0 SHALL force state IDLE, counter 0, stall=0, resp_valid=0, err=0, rdata=0.
REQ-029 Reset during WAIT SHALL abort the pending access: no array write and no response pulse.
REQ-030 The first request SHALL be accepted in the first cycle with RST=1.

Verification (LATENCY=2, ADDR_BITS=8 unless stated)
REQ-031 Basic write/read:
  - Write 0xDEADBEEF to 0x10: stall=1 in cycles 0-2, resp_valid=1 and err=0 in cycle 3.
  - Read 0x10: rdata=0xDEADBEEF in the resp_valid cycle.
REQ-032 Back-to-back: write held through DONE, read issued the next cycle -> read accepted in cycle 4, exactly one write to the array, resp_valid in cycle 7.
REQ-033 Misaligned write 0x13 of 0x11111111 -> err=1 with resp_valid; a following read of 0x10 still returns 0xDEADBEEF.
REQ-034 Simultaneous read and write -> err=1; array and rdata unchanged.
REQ-035 Abort under reset:
  - Stimulus: RST=0 for one cycle during WAIT of a write of 0xCAFEF00D to 0x20.
  - Response: stall=0, outputs zero, no resp_valid.
  - A subsequent read of 0x20 returns the prior value.
REQ-036 Aliasing and zero latency:
  - Read 0x410 returns the word at 0x10 (wrap).
  - With LATENCY=0: resp_valid in cycle 1 and stall=1 in cycle 0 only.
